// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate self-test sequencer.
// Truth constants index by gate_in value: bit v = expected output for vector v.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;
  localparam logic [3:0] TT_XNOR2 = 4'b1001;

endpackage

// File: rtl/gate_bist_if.sv
// Run-control, gate stimulus and result signals of the gate self-test sequencer.
// slave = the sequencer; master = the requester that also hosts the gate under test.
interface gate_bist_if #(
  parameter int unsigned N_IN = 2
);

  logic                    start;
  logic [N_IN-1:0]         gate_in;
  logic                    gate_out;
  logic                    busy;
  logic                    done;
  logic                    pass;
  logic [N_IN:0]           err_cnt;
  logic [(1 << N_IN)-1:0]  fail_vec;

  modport slave (
    input  start, gate_out,
    output gate_in, busy, done, pass, err_cnt, fail_vec
  );

  modport master (
    output start, gate_out,
    input  gate_in, busy, done, pass, err_cnt, fail_vec
  );

endinterface

// File: rtl/gate_bist_settle_timer.sv
// Loadable down-counter timing how long each vector is held before sampling.
// Loaded with SETTLE-1; 'expired' is high on the last hold cycle.
module gate_bist_settle_timer #(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned    CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer: sweeps all 2^N_IN vectors onto a gate, holds each SETTLE cycles,
// samples once, and accumulates mismatches against TRUTH.
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int unsigned            N_IN   = 2,
  parameter int unsigned            SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = TT_XNOR2
) (
  input  logic      clk,
  input  logic      rst,
  gate_bist_if.slave bus
);

  localparam int unsigned NV = 1 << N_IN;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     err_q, err_d;
  logic [NV-1:0]     fail_q, fail_d;
  logic              pass_q, pass_d;
  logic              tmr_load, tmr_en, tmr_expired;
  logic              last_vec, mismatch, active;

  gate_bist_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (tmr_load),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  assign last_vec = &vec_q;
  assign mismatch = (bus.gate_out != TRUTH[vec_q]);
  assign active   = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_DRIVE;
          vec_d    = '0;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          tmr_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        tmr_en = 1'b1;
        if (tmr_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          fail_d[vec_q] = 1'b1;
          err_d         = err_q + 1'b1;
        end
        // pass must reflect the final vector's compare, so it uses the updated count
        if (last_vec) begin
          state_d = ST_DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = ST_DRIVE;
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.gate_in  = active ? vec_q : '0;
  assign bus.busy     = active;
  assign bus.done     = (state_q == ST_DONE);
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_q;
  assign bus.fail_vec = fail_q;

endmodule
